ecc_ucode_seq: RTL and testbench

// - Parametrised microcode sequencer for the ECC point-arithmetic datapath: owns the program counter and

---
 rtl/ecc_ucode_pkg.sv | 50 +++++
 rtl/ecc_ucode_rom.sv | 41 ++++
 rtl/ecc_ucode_seq.sv | 172 +++++++++++++++++
 tb/tb_ecc_ucode_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_ucode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecc_ucode_pkg                                                              |
// | Opcodes, instruction field layout and FSM encoding for the ucode sequencer |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ecc_ucode_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LD   = 3'b001;
  localparam logic [2:0] OP_LOOP = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SQR  = 3'b110;

  // Instruction layout is {op, mode[2], fa, fb}; offsets depend on the address width.
  function automatic int fb_lsb(input int addr_w);
    return 0 * addr_w;
  endfunction

  function automatic int fa_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int mode_lsb(input int addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int op_lsb(input int addr_w);
    return 2 * addr_w + 2;
  endfunction

  function automatic logic [2:0] arith_op(input logic [1:0] sel);
    case (sel)
      2'd0:    return OP_ADD;
      2'd1:    return OP_SUB;
      2'd2:    return OP_MUL;
      default: return OP_SQR;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ecc_ucode_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecc_ucode_rom                                                              |
// | Fixed point-arithmetic microprogram; unlisted addresses read as NOP        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ecc_ucode_rom
  import ecc_ucode_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 21
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [INSTR_W-1:0] data
);

  localparam logic [ADDR_W-1:0] c_LOOP_A = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] c_TGT_A  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_LOOP_B = ADDR_W'(64);
  localparam logic [ADDR_W-1:0] c_TGT_B  = ADDR_W'(60);
  localparam logic [ADDR_W-1:0] c_LAST   = ADDR_W'(69);

  // Operand loads, an inner bit loop at 5 and a tail loop at 64 around arithmetic ops.
  always_comb begin
    data = '0;
    case (addr) inside
      [ADDR_W'(0) : ADDR_W'(4)]:
        data = INSTR_W'({OP_LD, 2'b00, addr, addr});
      c_LOOP_A:
        data = INSTR_W'({OP_LOOP, 2'b00, c_TGT_A, ADDR_W'(0)});
      c_LOOP_B:
        data = INSTR_W'({OP_LOOP, 2'b00, c_TGT_B, ADDR_W'(0)});
      [ADDR_W'(6) : ADDR_W'(63)], [ADDR_W'(65) : c_LAST]:
        data = INSTR_W'({arith_op(addr[1:0]), addr[1:0], addr, addr + ADDR_W'(1)});
      default:
        data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ecc_ucode_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecc_ucode_seq                                                              |
// | Microcode sequencer: PC/loop counter, registered issue, LOOP resolution.   |
// | Build option ECC_UCODE_LOAD_EN: writable register-array store + load port. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ecc_ucode_seq
  import ecc_ucode_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 21,
  parameter int OP_W     = 3,
  parameter int PROG_LEN = 70,
  parameter int LOOP_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LOOP_W-1:0]  loop_init,
  input  logic               stall,
`ifdef ECC_UCODE_LOAD_EN
  input  logic               load_we,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
`endif
  output logic [INSTR_W-1:0] instr,
  output logic               instr_vld,
  output logic [ADDR_W-1:0]  pc,
  output logic [LOOP_W-1:0]  loop_cnt,
  output logic               busy,
  output logic               done
);

  localparam int                 c_OP_LSB    = op_lsb(ADDR_W);
  localparam int                 c_FA_LSB    = fa_lsb(ADDR_W);
  localparam logic [ADDR_W:0]    c_PROG_LEN  = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(PROG_LEN - 1);
  localparam logic [INSTR_W-1:0] c_NOP_WORD  = INSTR_W'(OP_NOP) << c_OP_LSB;

  seq_state_t          r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [LOOP_W-1:0]   r_loop_cnt, w_loop_nxt;
  logic [INSTR_W-1:0]  r_instr, w_instr_nxt;
  logic                r_instr_vld, w_vld_nxt;
  logic                r_done, w_done_nxt;
  logic                r_end, w_end_nxt;

  logic [INSTR_W-1:0]  w_store_rd;
  logic [INSTR_W-1:0]  w_fetch;
  logic [OP_W-1:0]     w_op;
  logic [ADDR_W-1:0]   w_fa;
  logic                w_is_loop;
  logic                w_taken;
  logic                w_last;

`ifdef ECC_UCODE_LOAD_EN
  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [INSTR_W-1:0] r_store [c_DEPTH];

  // Program may only change while the sequencer is parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) r_store[i] <= '0;
    end else if (load_we && (r_state == ST_IDLE)) begin
      r_store[load_addr] <= load_data;
    end
  end

  assign w_store_rd = r_store[r_pc];
`else
  ecc_ucode_rom #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_rom (
    .addr (r_pc),
    .data (w_store_rd)
  );
`endif

  assign w_fetch   = ({1'b0, r_pc} < c_PROG_LEN) ? w_store_rd : '0;
  assign w_op      = w_fetch[c_OP_LSB +: OP_W];
  assign w_fa      = w_fetch[c_FA_LSB +: ADDR_W];
  assign w_is_loop = (w_op == OP_W'(OP_LOOP));
  assign w_taken   = w_is_loop && (r_loop_cnt != '0);
  assign w_last    = (r_pc == c_LAST_ADDR) && !w_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_loop_cnt  <= '0;
      r_instr     <= '0;
      r_instr_vld <= 1'b0;
      r_done      <= 1'b0;
      r_end       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_loop_cnt  <= w_loop_nxt;
      r_instr     <= w_instr_nxt;
      r_instr_vld <= w_vld_nxt;
      r_done      <= w_done_nxt;
      r_end       <= w_end_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_loop_nxt  = r_loop_cnt;
    w_instr_nxt = r_instr;
    w_vld_nxt   = r_instr_vld;
    w_done_nxt  = 1'b0;
    w_end_nxt   = r_end;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_pc_nxt    = '0;
      w_loop_nxt  = '0;
      w_instr_nxt = '0;
      w_vld_nxt   = 1'b0;
      w_end_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_vld_nxt = 1'b0;
          if (start) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = '0;
            w_loop_nxt  = loop_init;
            w_end_nxt   = 1'b0;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            // r_end: the last instruction is on the bus; it is consumed on this edge.
            if (r_end) begin
              w_state_nxt = ST_DONE;
              w_vld_nxt   = 1'b0;
              w_done_nxt  = 1'b1;
              w_end_nxt   = 1'b0;
            end else begin
              w_instr_nxt = w_is_loop ? c_NOP_WORD : w_fetch;
              w_vld_nxt   = 1'b1;
              w_pc_nxt    = w_taken ? w_fa : r_pc + ADDR_W'(1);
              w_end_nxt   = w_last;
              if (w_taken) w_loop_nxt = r_loop_cnt - LOOP_W'(1);
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_vld_nxt   = 1'b0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign instr     = r_instr;
  assign instr_vld = r_instr_vld;
  assign pc        = r_pc;
  assign loop_cnt  = r_loop_cnt;
  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ecc_ucode_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ecc_ucode_seq                                                           |
// | Scoreboard bench for ecc_ucode_seq (also covers ECC_UCODE_LOAD_EN build).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ecc_ucode_seq;

  localparam int PROG_LEN = 70;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  loop_init = '0;
`ifdef ECC_UCODE_LOAD_EN
  logic        load_we = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [20:0] load_data = '0;
`endif
  logic [20:0] instr;
  logic        instr_vld;
  logic [7:0]  pc;
  logic [7:0]  loop_cnt;
  logic        busy;
  logic        done;

  ecc_ucode_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .loop_init (loop_init),
    .stall     (stall),
`ifdef ECC_UCODE_LOAD_EN
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
`endif
    .instr     (instr),
    .instr_vld (instr_vld),
    .pc        (pc),
    .loop_cnt  (loop_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] w;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [20:0] tb_mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-written program listing.
  function automatic logic [20:0] golden(input int a);
    logic [7:0] a8;
    logic [2:0] op;
    a8 = 8'(a);
    if (a >= PROG_LEN) return 21'd0;
    if (a == 5)  return {3'b010, 2'b00, 8'd2, 8'd0};
    if (a == 64) return {3'b010, 2'b00, 8'd60, 8'd0};
    if (a <= 4)  return {3'b001, 2'b00, a8, a8};
    case (a % 4)
      0:       op = 3'b011;
      1:       op = 3'b100;
      2:       op = 3'b101;
      default: op = 3'b110;
    endcase
    return {op, a8[1:0], a8, a8 + 8'd1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected issue stream for one program run.
  task automatic build_exp(input logic [7:0] init);
    int          a;
    logic [7:0]  cnt;
    logic [20:0] w;
    exp_t        e;
    a   = 0;
    cnt = init;
    for (int n = 0; n < 2000; n++) begin
      w = (a < PROG_LEN) ? tb_mem[a] : 21'd0;
      if (w[20:18] == 3'b010) begin
        e.w = '0;
        if (cnt != 0) begin
          cnt   = cnt - 8'd1;
          e.cnt = cnt;
          exp_q.push_back(e);
          a = int'(w[15:8]);
          continue;
        end
        e.cnt = cnt;
        exp_q.push_back(e);
      end else begin
        e.w   = w;
        e.cnt = cnt;
        exp_q.push_back(e);
      end
      if (a == PROG_LEN - 1) break;
      a = (a + 1) % 256;
    end
  endtask

  // Monitor: one pop per accepted issue (instr_vld and no stall).
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) done_cnt++;
    if (rst_n && instr_vld && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got %0h expected no issue", instr);
      end else begin
        e = exp_q.pop_front();
        check("issue_instr", 32'(instr), 32'(e.w));
        check("issue_loop_cnt", 32'(loop_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] init, output int c0);
    build_exp(init);
    loop_init = init;
    start     = 1'b1;
    tick(1);
    c0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cd);
    cd = -1;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (done) begin
        cd = cyc;
        break;
      end
    end
  endtask

  task automatic wait_pc(input logic [7:0] target);
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (pc == target) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    check("wait_pc_reached", 32'(ok), 32'd1);
  endtask

  initial begin : stim
    int c0;
    int cd;
    int bad;
    int base;
    int n0;
    for (int a = 0; a < 256; a++) tb_mem[a] = golden(a);

    tick(3);
    rst_n = 1'b1;
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_loop_cnt", 32'(loop_cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (instr_vld !== 1'b0 || busy !== 1'b0 || pc !== 8'd0) bad++;
    end
    check("idle_quiet_cycles_bad", 32'(bad), 32'd0);

`ifdef ECC_UCODE_LOAD_EN
    for (int a = 0; a < PROG_LEN; a++) begin
      load_we   = 1'b1;
      load_addr = 8'(a);
      load_data = tb_mem[a];
      tick(1);
    end
    load_we = 1'b0;
`endif

    // Straight run, loops not taken.
    base = done_cnt;
    do_start(8'd0, c0);
    check("run_busy", 32'(busy), 32'd1);
    wait_done(300, cd);
    check("done_latency", 32'(cd - c0), 32'd71);
    check("done_vld_low", 32'(instr_vld), 32'd0);
    tick(1);
    check("after_done_low", 32'(done), 32'd0);
    check("after_done_busy", 32'(busy), 32'd0);
    tick(3);
    check("done_pulses", 32'(done_cnt - base), 32'd1);
    check("run0_drained", 32'(exp_q.size()), 32'd0);

    // Taken loop at 5 -> 2, three times.
    do_start(8'd3, c0);
    check("loop_init_captured", 32'(loop_cnt), 32'd3);
    wait_done(300, cd);
    check("loop_done_seen", 32'(cd >= 0), 32'd1);
    check("loop_cnt_final", 32'(loop_cnt), 32'd0);
    tick(2);
    check("loop_drained", 32'(exp_q.size()), 32'd0);

    // Stall at pc=10 for four cycles.
    do_start(8'd0, c0);
    wait_pc(8'd10);
    stall = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (pc !== 8'd10 || instr !== golden(9) || instr_vld !== 1'b1) bad++;
    end
    check("stall_frozen_bad", 32'(bad), 32'd0);
    stall = 1'b0;
    wait_done(300, cd);
    check("stall_done_seen", 32'(cd >= 0), 32'd1);
    tick(2);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Abort at pc=30, then restart from 0.
    base = done_cnt;
    do_start(8'd0, c0);
    n0 = exp_q.size() + 1;
    wait_pc(8'd30);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_vld", 32'(instr_vld), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_loop_cnt", 32'(loop_cnt), 32'd0);
    check("abort_consumed", 32'(n0 - exp_q.size()), 32'd31);
    exp_q.delete();
    tick(5);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    do_start(8'd0, c0);
    wait_done(300, cd);
    check("restart_done_latency", 32'(cd - c0), 32'd71);
    tick(2);
    check("restart_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-run.
    base = done_cnt;
    do_start(8'd2, c0);
    tick(10);
    rst_n = 1'b0;
    #1;
    check("midrst_vld", 32'(instr_vld), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_instr", 32'(instr), 32'd0);
    check("midrst_loop_cnt", 32'(loop_cnt), 32'd0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("midrst_no_done", 32'(done_cnt - base), 32'd0);

`ifdef ECC_UCODE_LOAD_EN
    // Store was cleared by reset; load one word, then try a write while running.
    for (int a = 0; a < 256; a++) tb_mem[a] = 21'd0;
    tb_mem[0] = 21'h1A0302;
    load_we   = 1'b1;
    load_addr = 8'd0;
    load_data = 21'h1A0302;
    tick(1);
    load_we = 1'b0;
    do_start(8'd0, c0);
    load_we   = 1'b1;
    load_addr = 8'd1;
    load_data = 21'h1FFFFF;
    tick(1);
    load_we = 1'b0;
    check("load_first_instr", 32'(instr), 32'h1A0302);
    wait_done(300, cd);
    check("load_done_seen", 32'(cd >= 0), 32'd1);
    tick(2);
    check("load_drained", 32'(exp_q.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
